// File: rtl/result_drain.sv
// Collects a fixed number of PE results into a small first-word fall-through FIFO
// and drains them to a consumer; signals completion and sticky overflow.
module result_drain #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  max_res,
    input  logic        se,
    input  logic [15:0] s_in,
    input  logic        sat_in,
    input  logic        r_ready,
    output logic        r_valid,
    output logic [15:0] r_data,
    output logic        r_sat,
    output logic        busy,
    output logic        done,
    output logic        ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 17;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_res_cntr;
    logic [7:0]      w_res_cntr_nxt;
    logic            r_ovf;
    logic            w_ovf_nxt;
    logic            r_done;
    logic            w_done_nxt;
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [EW-1:0]   r_mem [DEPTH];

    logic            w_push_req;
    logic            w_pop;
    logic            w_full;
    logic            w_push;
    logic            w_nonempty;

    assign w_nonempty = (r_count != '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_push_req = (r_state == ST_RUN) && se;
    assign w_pop      = w_nonempty && r_ready;
    assign w_push     = w_push_req && (!w_full || w_pop);

    // State register and run bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_res_cntr <= 8'd0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_res_cntr <= w_res_cntr_nxt;
            r_ovf      <= w_ovf_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Next-state: dropped pushes still consume a result slot so every run terminates
    always_comb begin
        w_state_nxt    = r_state;
        w_res_cntr_nxt = r_res_cntr;
        w_ovf_nxt      = r_ovf;
        w_done_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_ovf_nxt      = 1'b0;
                    w_res_cntr_nxt = max_res;
                    w_state_nxt    = (max_res == 8'd0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (se) begin
                    w_res_cntr_nxt = r_res_cntr - 8'd1;
                    if (!w_push) begin
                        w_ovf_nxt = 1'b1;
                    end
                    if (r_res_cntr == 8'd1) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!w_nonempty) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {sat_in, s_in};
        end
    end

    assign r_valid = w_nonempty;
    assign r_data  = w_nonempty ? r_mem[r_rptr][15:0] : 16'd0;
    assign r_sat   = w_nonempty ? r_mem[r_rptr][16]   : 1'b0;
    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_result_drain.sv
// Table-driven bench for result_drain with a scoreboard queue for the FIFO data.
module tb_result_drain;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  max_res;
    logic        se;
    logic [15:0] s_in;
    logic        sat_in;
    logic        r_ready;
    logic        r_valid;
    logic [15:0] r_data;
    logic        r_sat;
    logic        busy;
    logic        done;
    logic        ovf;

    always #5 clk = ~clk;

    result_drain #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .max_res (max_res),
        .se      (se),
        .s_in    (s_in),
        .sat_in  (sat_in),
        .r_ready (r_ready),
        .r_valid (r_valid),
        .r_data  (r_data),
        .r_sat   (r_sat),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf)
    );

    typedef struct packed {
        logic        st;
        logic [7:0]  mr;
        logic        se;
        logic [15:0] d;
        logic        sat;
        logic        rdy;
        logic        push;
        logic        busy;
        logic        done;
        logic        ovf;
    } vec_t;

    vec_t        vecs[$];
    logic [16:0] sb[$];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic [7:0] mr, input logic s, input logic [15:0] d,
                       input logic sat, input logic rdy, input logic push,
                       input logic b, input logic dn, input logic ov);
        vec_t x;
        x.st = st; x.mr = mr; x.se = s; x.d = d; x.sat = sat; x.rdy = rdy;
        x.push = push; x.busy = b; x.done = dn; x.ovf = ov;
        vecs.push_back(x);
    endtask

    // Drive one cycle, check outputs mid-cycle, then advance the scoreboard
    task automatic apply(input vec_t x, input string nm);
        start = x.st; max_res = x.mr; se = x.se; s_in = x.d; sat_in = x.sat; r_ready = x.rdy;
        @(negedge clk);
        chk({nm, " r_valid"}, 32'(r_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk({nm, " r_data"}, 32'(r_data), 32'(sb[0][15:0]));
            chk({nm, " r_sat"}, 32'(r_sat), 32'(sb[0][16]));
        end
        chk({nm, " busy"}, 32'(busy), 32'(x.busy));
        chk({nm, " done"}, 32'(done), 32'(x.done));
        chk({nm, " ovf"}, 32'(ovf), 32'(x.ovf));
        if (sb.size() != 0 && x.rdy) void'(sb.pop_front());
        if (x.push) sb.push_back({x.sat, x.d});
        @(posedge clk);
        #1;
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("%s[%0d]", tag, i));
        vecs.delete();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; max_res = 8'd0; se = 1'b0; s_in = 16'd0; sat_in = 1'b0; r_ready = 1'b0;
        @(negedge clk);
        chk("reset r_valid", 32'(r_valid), 32'(0));
        chk("reset r_data", 32'(r_data), 32'(0));
        chk("reset r_sat", 32'(r_sat), 32'(0));
        chk("reset busy", 32'(busy), 32'(0));
        chk("reset done", 32'(done), 32'(0));
        chk("reset ovf", 32'(ovf), 32'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Basic run of three results with continuous ready
        //  st  mr     se  data       sat   rdy  push busy done ovf
        add(1, 8'd3, 0, 16'd0,     0, 1, 0, 0, 0, 0);
        add(0, 8'd0, 1, 16'd100,   0, 1, 1, 1, 0, 0);
        add(0, 8'd0, 1, 16'hFFFB,  0, 1, 1, 1, 0, 0);
        add(0, 8'd0, 1, 16'h7FFF,  1, 1, 1, 1, 0, 0);
        add(0, 8'd0, 0, 16'd0,     0, 1, 0, 1, 0, 0);
        add(0, 8'd0, 0, 16'd0,     0, 1, 0, 1, 0, 0);
        add(0, 8'd0, 0, 16'd0,     0, 1, 0, 0, 1, 0);
        add(0, 8'd0, 0, 16'd0,     0, 1, 0, 0, 0, 0);
        run_vecs("basic");

        // Overflow: six results into a four-deep FIFO with the consumer stalled
        add(1, 8'd6, 0, 16'd0,     0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 6; i++)
            add(0, 8'd0, 1, 16'(i), 1'(i & 1), 0, (i <= 4) ? 1'b1 : 1'b0, 1, 0, (i == 6) ? 1'b1 : 1'b0);
        add(0, 8'd0, 1, 16'd99,    0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 5; i++)
            add(0, 8'd0, 0, 16'd0,  0, 1, 0, 1, 0, 1);
        add(0, 8'd0, 0, 16'd0,     0, 1, 0, 0, 1, 1);
        add(0, 8'd0, 0, 16'd0,     0, 1, 0, 0, 0, 1);
        // start with zero results clears ovf and completes two cycles later
        add(1, 8'd0, 0, 16'd0,     0, 1, 0, 0, 0, 1);
        add(0, 8'd0, 0, 16'd0,     0, 1, 0, 1, 0, 0);
        add(0, 8'd0, 0, 16'd0,     0, 1, 0, 0, 1, 0);
        add(0, 8'd0, 0, 16'd0,     0, 1, 0, 0, 0, 0);
        run_vecs("ovf");

        // Full FIFO with push and pop in the same cycle
        add(1, 8'd5, 0, 16'd0,     0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            add(0, 8'd0, 1, 16'(10 + i), 0, 0, 1, 1, 0, 0);
        add(0, 8'd0, 1, 16'd14,    1, 1, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++)
            add(0, 8'd0, 0, 16'd0,  0, 1, 0, 1, 0, 0);
        add(0, 8'd0, 0, 16'd0,     0, 1, 0, 0, 1, 0);
        run_vecs("fullpp");

        // se in IDLE and start during RUN are both ignored
        add(0, 8'd0, 1, 16'd555,   1, 1, 0, 0, 0, 0);
        add(1, 8'd2, 0, 16'd0,     0, 1, 0, 0, 0, 0);
        add(1, 8'd7, 1, 16'd21,    0, 1, 1, 1, 0, 0);
        add(1, 8'd9, 0, 16'd0,     0, 1, 0, 1, 0, 0);
        add(0, 8'd0, 1, 16'd22,    1, 1, 1, 1, 0, 0);
        add(0, 8'd0, 0, 16'd0,     0, 1, 0, 1, 0, 0);
        add(0, 8'd0, 0, 16'd0,     0, 1, 0, 1, 0, 0);
        add(0, 8'd0, 0, 16'd0,     0, 1, 0, 0, 1, 0);
        run_vecs("ignore");

        // Asynchronous reset with two entries queued mid-run
        add(1, 8'd4, 0, 16'd0,     0, 0, 0, 0, 0, 0);
        add(0, 8'd0, 1, 16'h1111,  1, 0, 1, 1, 0, 0);
        add(0, 8'd0, 1, 16'h2222,  0, 0, 1, 1, 0, 0);
        add(0, 8'd0, 0, 16'd0,     0, 0, 0, 1, 0, 0);
        run_vecs("prerst");
        #2 rst = 1'b1;
        #1;
        chk("midrst r_valid", 32'(r_valid), 32'(0));
        chk("midrst r_data", 32'(r_data), 32'(0));
        chk("midrst r_sat", 32'(r_sat), 32'(0));
        chk("midrst busy", 32'(busy), 32'(0));
        chk("midrst done", 32'(done), 32'(0));
        chk("midrst ovf", 32'(ovf), 32'(0));
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        add(0, 8'd0, 1, 16'd7,     0, 1, 0, 0, 0, 0);
        add(1, 8'd1, 0, 16'd0,     0, 1, 0, 0, 0, 0);
        add(0, 8'd0, 1, 16'd8,     1, 1, 1, 1, 0, 0);
        add(0, 8'd0, 0, 16'd0,     0, 1, 0, 1, 0, 0);
        add(0, 8'd0, 0, 16'd0,     0, 1, 0, 1, 0, 0);
        add(0, 8'd0, 0, 16'd0,     0, 1, 0, 0, 1, 0);
        add(0, 8'd0, 0, 16'd0,     0, 1, 0, 0, 0, 0);
        run_vecs("postrst");

        chk("scoreboard drained", 32'(sb.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/result_drain.md
RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 Parameter DEPTH, default 4, result FIFO depth; legal values are powers of 2 from 2 to 16.
REQ-002 Clocking is one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 start  in  1  one-cycle pulse that begins a collection run.
REQ-006 max_res  in  8  number of results expected per run; sampled when start is accepted.
REQ-007 se  in  1  PE sum-end strobe; s_in and sat_in are valid in this cycle.
REQ-008 s_in  in  16  signed PE accumulator result.
REQ-009 sat_in  in  1  PE saturation flag, qualified by se.
REQ-010 r_ready  in  1  consumer accepts the head entry.
REQ-011 r_valid  out  1  head entry is valid.
REQ-012 r_data  out  16  signed head result.
REQ-013 r_sat  out  1  saturation flag of the head entry.
REQ-014 busy  out  1  high whenever the state is not IDLE.
REQ-015 done  out  1  one-cycle pulse at the end of a run.
REQ-016 ovf  out  1  sticky overflow flag; a result was dropped.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-018 In IDLE, start SHALL latch max_res into res_cntr and move to RUN; if max_res=0, start SHALL move directly to DRAIN.
REQ-019 In RUN, each se SHALL be a push request of {sat_in, s_in}; an accepted push SHALL decrement res_cntr.
REQ-020 When the push that brings res_cntr to 0 is accepted, the FSM SHALL move to DRAIN in the next cycle.
REQ-021 A push dropped for overflow SHALL still decrement res_cntr, so the run always terminates after max_res se strobes.
REQ-022 In DRAIN, the FSM SHALL stay until the FIFO is empty, then move to IDLE and pulse done for exactly one cycle on the transition.
REQ-023 se in IDLE or DRAIN SHALL be ignored: no push, no count change, no ovf.
REQ-024 start outside IDLE SHALL be ignored.
REQ-025 A pop SHALL occur when r_valid and r_ready are both high; r_valid SHALL equal (count != 0).
REQ-026 r_data and r_sat SHALL be driven from the head entry (first-word fall-through); a pushed entry SHALL be visible on r_data one cycle after the push edge.
REQ-027 A push is accepted when count < DEPTH, or when count = DEPTH and a pop occurs in the same cycle.
REQ-028 A simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-029 A push request while full with no pop SHALL drop the data, set ovf, and leave FIFO contents unchanged.
REQ-030 ovf SHALL be cleared only by rst or by an accepted start.
REQ-031 Read and write pointers SHALL be log2(DEPTH) bits, wrap modulo DEPTH, and be used with a separate count of log2(DEPTH)+1 bits.
REQ-032 r_valid and r_ready are independent of state, so draining continues in every state.
REQ-033 No arithmetic is performed on data; s_in SHALL be stored bit-exact.

Reset
REQ-034 While rst is high: state=IDLE, count=0, pointers=0, res_cntr=0, r_valid=0, r_data=0, r_sat=0, busy=0, done=0, ovf=0.
REQ-035 Assertion of rst mid-run SHALL discard all FIFO contents immediately, with no done pulse.
REQ-036 After rst deasserts, the first edge SHALL behave as IDLE.

Verification
REQ-037 start with max_res=3; se ×3 carrying 100, -5, 0x7FFF with sat=0,0,1; r_ready=1 -> r_data sequence 100, -5, 32767 with r_sat 0,0,1; done pulses once when the FIFO empties; busy falls the same cycle.
REQ-038 DEPTH=4, max_res=6, r_ready=0, six se strobes -> first 4 values stored, ovf=1, FSM reaches DRAIN; then r_ready=1 -> 4 values out in order, done pulses, ovf stays 1 until the next start.
REQ-039 FIFO full, se and pop in the same cycle -> push accepted, count stays 4, ovf stays 0, order preserved.
REQ-040 start with max_res=0 -> DRAIN then IDLE; done pulses 2 cycles after start; no data emitted.
REQ-041 se in IDLE, and a second start during RUN -> both ignored, res_cntr unaffected.
REQ-042 rst asserted with 2 entries queued in RUN -> r_valid=0, busy=0, done=0 immediately (asynchronously).
